spu_decode_stage: RTL and testbench
===================================

// Module: spu_decode_stage
// PURPOSE
//  Parametrised SPU decode stage: splits the 32-bit instruction, drives register-file read addresses,
//  forwards operands from NUM_FWD later stages, resolves beq-style branches in ID and registers results
//  into an ID/EX pipeline register with valid/ready handshake. Adds load-use stall, taken-branch squash
//  and external flush. Sits between fetch (IF/ID) and execute; register file is external.
// PARAMETERS
//  DATA_W   128  register/operand width
//  PC_W     11   PC width (byte address, PC+8 supplied by fetch)
//  RA_W     7    register address width
//  NUM_FWD  2    forwarding sources; index 0 = youngest = highest priority
// PORTS
//  clk           in   1              rising-edge clock
//  reset         in   1              synchronous, active-high
//  in_valid      in   1              fetch presents instruction
//  in_ready      out  1              decode accepts instruction this cycle
//  in_instr      in   32             instruction word
//  in_pc8        in   PC_W           PC+8 of instruction
//  imm_sel       in   2              0:I7 sext [20:14] 1:I10 sext [23:14] 2:I16 sext [22:7] 3:I18 zext [24:7]
//  is_branch     in   1              instruction is compare-equal branch
//  rf_ra_addr/rf_rb_addr/rf_rc_addr  out  RA_W  = instr[13:7] / [20:14] / [6:0]
//  rf_ra_data/rf_rb_data/rf_rc_data  in   DATA_W  combinational read data
//  fwd_valid     in   NUM_FWD        source i holds a result to write
//  fwd_rt        in   NUM_FWD*RA_W   destination of source i
//  fwd_data      in   NUM_FWD*DATA_W result of source i
//  ex_load       in   1              instruction now in EX is a valid load
//  ex_rt         in   RA_W           its destination
//  flush         in   1              later-stage redirect
//  out_valid     out  1              ID/EX register holds an instruction
//  out_ready     in   1              execute accepts
//  out_opcode    out  11             instr[31:21]
//  out_ra/out_rb/out_rc  out  DATA_W forwarded operands
//  out_imm       out  DATA_W         extended immediate
//  out_rt        out  RA_W           instr[6:0]
//  out_rrr_rt    out  RA_W           instr[27:21] (RRR-form destination)
//  out_pc8       out  PC_W           carried PC+8
//  br_taken      out  1              one-cycle pulse: branch resolved taken
//  br_target     out  PC_W           registered target, valid with br_taken
// BEHAVIOUR
//  - Reset: out_valid=0, all out_* =0, br_taken=0, br_target=0, state=RUN; in_ready=0 during reset cycle.
//  - advance = out_ready | ~out_valid. stall = ex_load & (ex_rt==rf_ra_addr | ex_rt==rf_rb_addr | ex_rt==rf_rc_addr).
//  - in_ready = advance & ~stall & ~flush (combinational).
//  - Accept (in_valid & in_ready) in RUN: ID/EX loads all fields next edge, out_valid<=1.
//  - advance & no accept: out_valid<=0 (bubble). ~advance: ID/EX holds every field.
//  - Forwarding per operand: lowest i with fwd_valid[i] & fwd_rt[i]==addr supplies data, else rf data.
//  - Immediate per imm_sel, sign/zero extended to DATA_W.
//  - Branch target = (in_pc8 + {imm[PC_W-4:0],3'b000}) mod 2^PC_W; wrap-around silent.
//  - Branch taken = accept & is_branch & (fwd RA == fwd RB); br_taken pulses next cycle, 1 cycle only.
//  - States: RUN -> SQUASH on taken-branch accept; SQUASH: in_ready per rule, accepted instruction
//    is discarded (out_valid<=0), return to RUN; SQUASH with no accept stays SQUASH.
//  - flush: next edge out_valid<=0, br_taken<=0, state<=RUN; flush beats stall, accept and branch.
//  - Branch itself proceeds to EX with out_valid=1 (no write, opcode passed).
//  - Reset mid-operation overrides everything, same values as above.
// TESTING
//  - ai r5,r3,-1 (imm_sel0, instr[20:14]=7'h7F) -> out_imm=all-ones, out_ra=rf data r3, 1-cycle latency.
//  - fwd_valid=2'b11, both fwd_rt=3, data0=A, data1=B, ra=r3 -> out_ra=A (index 0 wins).
//  - ex_load=1, ex_rt=5, instr reads r5 -> in_ready=0, bubble out_valid=0; ex_load drops -> accepted.
//  - Branch, in_pc8=0x7F8, imm=2, RA==RB -> br_taken=1 one cycle, br_target=0x008; next instr squashed.
//  - out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; release -> next accepted.
//  - flush asserted same cycle as taken-branch accept -> no br_taken, out_valid=0, state RUN.

Source files
------------

// File: rtl/spu_decode_stage.sv
// spu_decode_stage: SPU instruction decode with operand forwarding, in-ID branch resolution and an ID/EX handshake register
module spu_decode_stage #(
    parameter int DATA_W  = 128,
    parameter int PC_W    = 11,
    parameter int RA_W    = 7,
    parameter int NUM_FWD = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [PC_W-1:0]           in_pc8,
    input  logic [1:0]                imm_sel,
    input  logic                      is_branch,
    output logic [RA_W-1:0]           rf_ra_addr,
    output logic [RA_W-1:0]           rf_rb_addr,
    output logic [RA_W-1:0]           rf_rc_addr,
    input  logic [DATA_W-1:0]         rf_ra_data,
    input  logic [DATA_W-1:0]         rf_rb_data,
    input  logic [DATA_W-1:0]         rf_rc_data,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD*RA_W-1:0]   fwd_rt,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic                      ex_load,
    input  logic [RA_W-1:0]           ex_rt,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [10:0]               out_opcode,
    output logic [DATA_W-1:0]         out_ra,
    output logic [DATA_W-1:0]         out_rb,
    output logic [DATA_W-1:0]         out_rc,
    output logic [DATA_W-1:0]         out_imm,
    output logic [RA_W-1:0]           out_rt,
    output logic [RA_W-1:0]           out_rrr_rt,
    output logic [PC_W-1:0]           out_pc8,
    output logic                      br_taken,
    output logic [PC_W-1:0]           br_target
);
    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] SQUASH = 1'b1;

    typedef struct packed {
        logic [10:0]       opcode;
        logic [DATA_W-1:0] ra;
        logic [DATA_W-1:0] rb;
        logic [DATA_W-1:0] rc;
        logic [DATA_W-1:0] imm;
        logic [RA_W-1:0]   rt;
        logic [RA_W-1:0]   rrr_rt;
        logic [PC_W-1:0]   pc8;
    } idex_t;

    idex_t           idex_d, idex_q;
    logic            out_valid_d, out_valid_q;
    logic            br_taken_d, br_taken_q;
    logic [PC_W-1:0] br_target_d, br_target_q;
    logic [0:0]      state_d, state_q;

    logic [DATA_W-1:0] fa, fb, fc, imm;
    logic [PC_W-1:0]   target;
    logic              advance, stall, accept, run, taken;

    // Scan from oldest to youngest so the lowest matching index overrides.
    function automatic logic [DATA_W-1:0] fwd_sel(input logic [RA_W-1:0] a, input logic [DATA_W-1:0] rf);
        fwd_sel = rf;
        for (int i = NUM_FWD - 1; i >= 0; i--)
            if (fwd_valid[i] && fwd_rt[i*RA_W +: RA_W] == a) fwd_sel = fwd_data[i*DATA_W +: DATA_W];
    endfunction

    assign rf_ra_addr = RA_W'(in_instr[13:7]);
    assign rf_rb_addr = RA_W'(in_instr[20:14]);
    assign rf_rc_addr = RA_W'(in_instr[6:0]);

    assign fa = fwd_sel(rf_ra_addr, rf_ra_data);
    assign fb = fwd_sel(rf_rb_addr, rf_rb_data);
    assign fc = fwd_sel(rf_rc_addr, rf_rc_data);

    assign imm = imm_sel == 2'd0 ? {{(DATA_W-7){in_instr[20]}}, in_instr[20:14]}
               : imm_sel == 2'd1 ? {{(DATA_W-10){in_instr[23]}}, in_instr[23:14]}
               : imm_sel == 2'd2 ? {{(DATA_W-16){in_instr[22]}}, in_instr[22:7]}
               :                   {{(DATA_W-18){1'b0}}, in_instr[24:7]};

    assign target   = in_pc8 + {imm[PC_W-4:0], 3'b000};
    assign advance  = out_ready | ~out_valid_q;
    assign stall    = ex_load & (ex_rt == rf_ra_addr | ex_rt == rf_rb_addr | ex_rt == rf_rc_addr);
    assign in_ready = ~reset & advance & ~stall & ~flush;
    assign accept   = in_valid & in_ready;
    assign run      = state_q == RUN;
    assign taken    = accept & run & is_branch & (fa == fb);

    always_comb begin
        idex_d      = idex_q;
        out_valid_d = out_valid_q;
        state_d     = state_q;
        br_taken_d  = taken;
        br_target_d = taken ? target : br_target_q;
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = RUN;
        end else if (advance) begin
            out_valid_d = accept & run;
            state_d     = accept ? (taken ? SQUASH : RUN) : state_q;
            if (accept & run) begin
                idex_d.opcode = in_instr[31:21];
                idex_d.ra     = fa;
                idex_d.rb     = fb;
                idex_d.rc     = fc;
                idex_d.imm    = imm;
                idex_d.rt     = rf_rc_addr;
                idex_d.rrr_rt = RA_W'(in_instr[27:21]);
                idex_d.pc8    = in_pc8;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q      <= '0;
            out_valid_q <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            state_q     <= RUN;
        end else begin
            idex_q      <= idex_d;
            out_valid_q <= out_valid_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            state_q     <= state_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_opcode = idex_q.opcode;
    assign out_ra     = idex_q.ra;
    assign out_rb     = idex_q.rb;
    assign out_rc     = idex_q.rc;
    assign out_imm    = idex_q.imm;
    assign out_rt     = idex_q.rt;
    assign out_rrr_rt = idex_q.rrr_rt;
    assign out_pc8    = idex_q.pc8;
    assign br_taken   = br_taken_q;
    assign br_target  = br_target_q;
endmodule

// File: tb/tb_spu_decode_stage.sv
// tb_spu_decode_stage: directed vectors with hand-computed expectations for the SPU decode stage
module tb_spu_decode_stage;
    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, is_branch, ex_load, flush, out_valid, out_ready, br_taken;
    logic [31:0]  in_instr;
    logic [10:0]  in_pc8, out_pc8, br_target;
    logic [1:0]   imm_sel, fwd_valid;
    logic [6:0]   rf_ra_addr, rf_rb_addr, rf_rc_addr, ex_rt, out_rt, out_rrr_rt;
    logic [127:0] rf_ra_data, rf_rb_data, rf_rc_data, out_ra, out_rb, out_rc, out_imm;
    logic [13:0]  fwd_rt;
    logic [255:0] fwd_data;
    logic [10:0]  out_opcode;
    int           n_chk = 0, n_fail = 0;

    localparam logic [127:0] VA = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] VB = 128'hBBBB_9999_8888_7777_6666_5555_4444_3333;

    always #5 clk = ~clk;

    spu_decode_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc8(in_pc8), .imm_sel(imm_sel), .is_branch(is_branch),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr), .rf_rc_addr(rf_rc_addr),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data), .rf_rc_data(rf_rc_data),
        .fwd_valid(fwd_valid), .fwd_rt(fwd_rt), .fwd_data(fwd_data), .ex_load(ex_load), .ex_rt(ex_rt),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_ra(out_ra), .out_rb(out_rb), .out_rc(out_rc), .out_imm(out_imm), .out_rt(out_rt),
        .out_rrr_rt(out_rrr_rt), .out_pc8(out_pc8), .br_taken(br_taken), .br_target(br_target)
    );

    function automatic logic [127:0] rfv(input logic [6:0] a);
        return {64'hA5A5_0000_0000_0000, 57'd0, a};
    endfunction

    assign rf_ra_data = rfv(rf_ra_addr);
    assign rf_rb_data = rfv(rf_rb_addr);
    assign rf_rc_data = rfv(rf_rc_addr);

    function automatic logic [31:0] mk(input logic [10:0] op, input logic [6:0] rb, ra, rt);
        return {op, rb, ra, rt};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [31:0]  imm_instr [8];
    logic [1:0]   imm_s     [8];
    logic [127:0] imm_exp   [8];

    initial begin
        imm_instr = '{32'h01FF_FF80, 32'h01FF_FF80, 32'h01FF_FF80, 32'h01FF_FF80,
                      32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000};
        imm_s     = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        imm_exp   = '{'1, '1, '1, 128'h3FFFF, 128'h0, ~128'h1FF, 128'h0, 128'h10000};
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc8 = '0; imm_sel = '0; is_branch = 1'b0;
        fwd_valid = '0; fwd_rt = '0; fwd_data = '0; ex_load = 1'b0; ex_rt = '0; flush = 1'b0; out_ready = 1'b1;
        step; step;
        in_valid = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ra", out_ra, 0);
        chk("rst_br_taken", br_taken, 0);
        chk("rst_br_target", br_target, 0);
        in_valid = 1'b0;
        step;
        reset = 1'b0;
        // ai r5,r3,-1
        in_valid = 1'b1; in_instr = mk(11'h1C0, 7'h7F, 7'd3, 7'd5); in_pc8 = 11'h100; imm_sel = 2'd0;
        #1 chk("ai_in_ready", in_ready, 1);
        step;
        chk("ai_valid", out_valid, 1);
        chk("ai_imm", out_imm, '1);
        chk("ai_ra", out_ra, rfv(7'd3));
        chk("ai_rb", out_rb, rfv(7'h7F));
        chk("ai_rt", out_rt, 7'd5);
        chk("ai_rrr_rt", out_rrr_rt, 7'h40);
        chk("ai_opcode", out_opcode, 11'h1C0);
        chk("ai_pc8", out_pc8, 11'h100);
        for (int i = 0; i < 8; i++) begin
            in_instr = imm_instr[i]; imm_sel = imm_s[i];
            step;
            chk($sformatf("imm_%0d", i), out_imm, imm_exp[i]);
        end
        in_instr = mk(11'h011, 7'd9, 7'd3, 7'd4);
        fwd_rt = {7'd3, 7'd3}; fwd_data = {VB, VA}; fwd_valid = 2'b11;
        step;
        chk("fwd_prio0", out_ra, VA);
        chk("fwd_rb_rf", out_rb, rfv(7'd9));
        fwd_valid = 2'b10;
        step;
        chk("fwd_src1", out_ra, VB);
        fwd_rt = {7'd9, 7'd3}; fwd_valid = 2'b11;
        step;
        chk("fwd_ra0", out_ra, VA);
        chk("fwd_rb1", out_rb, VB);
        fwd_valid = 2'b00;
        step;
        chk("fwd_none", out_ra, rfv(7'd3));
        ex_load = 1'b1; ex_rt = 7'd5; in_instr = mk(11'h022, 7'd1, 7'd2, 7'd5);
        #1 chk("stall_in_ready", in_ready, 0);
        step;
        chk("stall_bubble", out_valid, 0);
        ex_load = 1'b0;
        #1 chk("unstall_in_ready", in_ready, 1);
        step;
        chk("unstall_valid", out_valid, 1);
        chk("unstall_rc", out_rc, rfv(7'd5));
        // taken branch with wrapping target 0x7F8 + (2<<3)
        in_pc8 = 11'h7F8; imm_sel = 2'd0; is_branch = 1'b1; in_instr = mk(11'h040, 7'd2, 7'd2, 7'd0);
        step;
        chk("br_taken", br_taken, 1);
        chk("br_target", br_target, 11'h008);
        chk("br_valid", out_valid, 1);
        chk("br_opcode", out_opcode, 11'h040);
        is_branch = 1'b0; in_instr = mk(11'h050, 7'd1, 7'd1, 7'd1);
        #1 chk("sq_in_ready", in_ready, 1);
        step;
        chk("br_pulse", br_taken, 0);
        chk("sq_valid", out_valid, 0);
        step;
        chk("post_sq_valid", out_valid, 1);
        chk("post_sq_opcode", out_opcode, 11'h050);
        is_branch = 1'b1; in_instr = mk(11'h041, 7'd2, 7'd3, 7'd0);
        step;
        chk("nt_br_taken", br_taken, 0);
        chk("nt_br_valid", out_valid, 1);
        is_branch = 1'b0; in_instr = mk(11'h060, 7'd1, 7'd1, 7'd1);
        step;
        chk("nt_next_valid", out_valid, 1);
        chk("nt_next_opcode", out_opcode, 11'h060);
        out_ready = 1'b0; in_instr = mk(11'h2AA, 7'd1, 7'd1, 7'd1);
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("bp_in_ready_%0d", i), in_ready, 0);
            step;
            chk($sformatf("bp_valid_%0d", i), out_valid, 1);
            chk($sformatf("bp_opcode_%0d", i), out_opcode, 11'h060);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1);
        step;
        chk("bp_release_opcode", out_opcode, 11'h2AA);
        flush = 1'b1; is_branch = 1'b1; in_instr = mk(11'h040, 7'd2, 7'd2, 7'd0);
        #1 chk("fl_in_ready", in_ready, 0);
        step;
        chk("fl_br_taken", br_taken, 0);
        chk("fl_valid", out_valid, 0);
        flush = 1'b0; is_branch = 1'b0; in_instr = mk(11'h155, 7'd1, 7'd1, 7'd1);
        step;
        chk("fl_run_valid", out_valid, 1);
        chk("fl_run_opcode", out_opcode, 11'h155);
        reset = 1'b1;
        step;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_opcode", out_opcode, 0);
        chk("mid_rst_target", br_target, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        reset = 1'b0; in_valid = 1'b0;
        step;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
